fifo_sync: RTL and testbench
============================

Name: fifo_sync

Overview:
Single-clock synchronous FIFO built on an inferred RAM array. It is the parametrised successor to the team's 2-port RAM. It adds read/write pointer management, an occupancy count, full/empty and programmable almost-full/almost-empty flags, and overflow/underflow pulses. It is used as the standard buffering element between streaming blocks (UART, LFSR, datapath stages) within one clock domain.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 256, number of storage words (>=2, any integer; power of 2 not required)
AF_LEVEL, DEPTH-1, almost-full threshold: o_af asserted when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 1, almost-empty threshold: o_ae asserted when count <= AE_LEVEL (0..DEPTH-1)

Ports:
i_clk  in  1  single clock; all logic on rising edge
i_rst  in  1  synchronous reset, active-high
i_wr_dv  in  1  write request; i_wr_data captured if accepted
i_wr_data  in  WIDTH  write data
i_rd_en  in  1  read request
o_rd_dv  out  1  read data valid, 1 cycle after accepted read
o_rd_data  out  WIDTH  read data, valid only while o_rd_dv=1
o_count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
o_full  out  1  count == DEPTH
o_empty  out  1  count == 0
o_af  out  1  count >= AF_LEVEL
o_ae  out  1  count <= AE_LEVEL
o_overflow  out  1  one-cycle pulse: write requested while full
o_underflow  out  1  one-cycle pulse: read requested while empty

Behaviour:
- Reset (i_rst=1 at posedge): write ptr=0, read ptr=0, count=0, o_rd_dv=0, o_rd_data=0, o_empty=1, o_full=0, o_ae=1, o_af=0, o_overflow=0, o_underflow=0. RAM contents are not reset. Reset mid-operation discards all stored words; the following cycle behaves as an empty FIFO.
- Accept rules use flags registered as of the current cycle, not next-state flags:
  - wr_ok = i_wr_dv & ~o_full
  - rd_ok = i_rd_en & ~o_empty
- Write: on wr_ok, mem[wr_ptr] <= i_wr_data. wr_ptr increments and wraps DEPTH-1 -> 0.
- Read: on rd_ok, o_rd_data <= mem[rd_ptr] and o_rd_dv <= 1 on the next edge (latency 1). rd_ptr increments and wraps DEPTH-1 -> 0. If rd_ok=0, o_rd_dv <= 0 and o_rd_data holds its last value.
- Count: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither. All flags derive from the registered count and update in the same cycle as the count.
- Simultaneous read+write:
  - Not full and not empty: both accepted, count unchanged.
  - Full: read accepted, write rejected, o_overflow pulses, count -> DEPTH-1.
  - Empty: write accepted, read rejected, o_underflow pulses, count -> 1. Data written in that cycle is readable no earlier than the next cycle (no fall-through).
- Rejected operations leave pointers, count and memory unchanged.
- o_overflow/o_underflow are registered and assert on the edge following the offending request, for exactly one cycle per offending cycle.
- Ordering is strict FIFO. Data read equals data written, in order, across any number of pointer wraps.
- Pointer width is $clog2(DEPTH). Wrap is by explicit compare to DEPTH-1, so non-power-of-2 DEPTH works.
- RAM is inferred as simple dual-port (one write port, one registered read port) so it maps to block RAM.

Test Plan:
1. WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1. After reset, write 0x11,0x22,0x33,0x44 on consecutive cycles -> o_count 1,2,3,4; o_ae drops when count=2; o_af rises at count=3; o_full=1 at count=4.
2. From full, write 0x55 -> o_overflow pulses 1 cycle, count stays 4. Then read 4 times -> o_rd_dv=1 one cycle after each read, data 0x11,0x22,0x33,0x44; o_empty=1 after the last read.
3. From empty, assert i_rd_en -> o_underflow pulses, o_rd_dv stays 0. Assert write 0xA5 and read together on empty -> count=1, no o_rd_dv. Next-cycle read -> o_rd_dv with 0xA5.
4. Full FIFO, simultaneous read+write 0x66 -> read returns oldest word, write rejected, o_overflow=1, count=3.
5. DEPTH=5 (non-power-of-2), stream 20 words with concurrent reads at 50% duty -> output sequence matches input exactly across wraps; count never exceeds 5.
6. Fill to 3 words, assert i_rst for 1 cycle during a read -> next cycle count=0, o_empty=1, o_rd_dv=0, o_rd_data=0. Subsequent write/read of 0x7E returns 0x7E.

Source files
------------

// File: rtl/fifo_sync.sv
// Single-clock FIFO over an inferred simple dual-port RAM with occupancy count,
// threshold flags and registered overflow/underflow pulses.
module fifo_sync #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned AE_LEVEL = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_wr_dv,
  input  logic [WIDTH-1:0]           i_wr_data,
  input  logic                       i_rd_en,
  output logic                       o_rd_dv,
  output logic [WIDTH-1:0]           o_rd_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_af,
  output logic                       o_ae,
  output logic                       o_overflow,
  output logic                       o_underflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_LEVEL);

  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_rd_dv;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_wr_ok;
  logic             w_rd_ok;
  logic [PTR_W-1:0] w_wr_ptr_nxt;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [CNT_W-1:0] w_count_nxt;

  // Accept decisions use the flags as registered this cycle, never next-state.
  assign w_wr_ok = i_wr_dv & ~o_full;
  assign w_rd_ok = i_rd_en & ~o_empty;

  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_count_nxt  = r_count;
    if (w_wr_ok) begin
      w_wr_ptr_nxt = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
    end
    if (w_rd_ok) begin
      w_rd_ptr_nxt = (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
    end
    case ({w_wr_ok, w_rd_ok})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Write port kept reset-free so the array maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rd_dv     <= 1'b0;
      r_rd_data   <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_count     <= w_count_nxt;
      r_rd_dv     <= w_rd_ok;
      r_overflow  <= i_wr_dv & o_full;
      r_underflow <= i_rd_en & o_empty;
      if (w_rd_ok) begin
        r_rd_data <= r_mem[r_rd_ptr];
      end
    end
  end

  assign o_rd_dv     = r_rd_dv;
  assign o_rd_data   = r_rd_data;
  assign o_count     = r_count;
  assign o_full      = (r_count == CNT_FULL);
  assign o_empty     = (r_count == '0);
  assign o_af        = (r_count >= CNT_AF);
  assign o_ae        = (r_count <= CNT_AE);
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

endmodule

// File: tb/tb_fifo_sync.sv
// Drives a DEPTH=4 and a DEPTH=5 FIFO against a queue-based model of the FIFO rules.
module tb_fifo_sync;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       wr_a = 1'b0, rd_a = 1'b0;
  logic [7:0] wd_a = 8'h00;
  logic       dv_a, full_a, empty_a, af_a, ae_a, ovf_a, unf_a;
  logic [7:0] data_a;
  logic [2:0] cnt_a;

  logic       wr_b = 1'b0, rd_b = 1'b0;
  logic [7:0] wd_b = 8'h00;
  logic       dv_b, full_b, empty_b, af_b, ae_b, ovf_b, unf_b;
  logic [7:0] data_b;
  logic [2:0] cnt_b;

  always #5 clk = ~clk;

  fifo_sync #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) u_fifo_a (
    .i_clk(clk), .i_rst(rst), .i_wr_dv(wr_a), .i_wr_data(wd_a), .i_rd_en(rd_a),
    .o_rd_dv(dv_a), .o_rd_data(data_a), .o_count(cnt_a), .o_full(full_a),
    .o_empty(empty_a), .o_af(af_a), .o_ae(ae_a), .o_overflow(ovf_a), .o_underflow(unf_a)
  );

  fifo_sync #(.WIDTH(8), .DEPTH(5)) u_fifo_b (
    .i_clk(clk), .i_rst(rst), .i_wr_dv(wr_b), .i_wr_data(wd_b), .i_rd_en(rd_b),
    .o_rd_dv(dv_b), .o_rd_data(data_b), .o_count(cnt_b), .o_full(full_b),
    .o_empty(empty_b), .o_af(af_b), .o_ae(ae_b), .o_overflow(ovf_b), .o_underflow(unf_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  int cur = 0;
  int depth = 4;
  int af_lvl = 3;
  int ae_lvl = 1;
  logic [7:0] mq[$];
  int exp_data = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic sel(input int inst);
    cur    = inst;
    depth  = (inst == 0) ? 4 : 5;
    af_lvl = (inst == 0) ? 3 : 4;
    ae_lvl = 1;
  endtask

  // One clock: drive the selected FIFO, advance the model, compare every output.
  task automatic step(input logic wr, input logic [7:0] d, input logic rd, input logic rs);
    int   sz;
    int   exp_dv, exp_ovf, exp_unf;
    logic g_dv, g_full, g_empty, g_af, g_ae, g_ovf, g_unf;
    logic [7:0] g_data;
    logic [2:0] g_cnt;
    if (cur == 0) begin
      wr_a = wr; wd_a = d; rd_a = rd;
    end else begin
      wr_b = wr; wd_b = d; rd_b = rd;
    end
    rst = rs;
    @(posedge clk);
    #1;
    sz = mq.size();
    if (rs) begin
      mq.delete();
      exp_dv = 0; exp_data = 0; exp_ovf = 0; exp_unf = 0;
    end else begin
      exp_ovf = (wr && sz == depth) ? 1 : 0;
      exp_unf = (rd && sz == 0) ? 1 : 0;
      exp_dv  = 0;
      if (rd && sz != 0) begin
        exp_dv   = 1;
        exp_data = mq.pop_front();
      end
      if (wr && sz != depth) mq.push_back(d);
    end
    wr_a = 1'b0; rd_a = 1'b0; wr_b = 1'b0; rd_b = 1'b0; rst = 1'b0;
    if (cur == 0) begin
      g_dv = dv_a; g_data = data_a; g_cnt = cnt_a; g_full = full_a; g_empty = empty_a;
      g_af = af_a; g_ae = ae_a; g_ovf = ovf_a; g_unf = unf_a;
    end else begin
      g_dv = dv_b; g_data = data_b; g_cnt = cnt_b; g_full = full_b; g_empty = empty_b;
      g_af = af_b; g_ae = ae_b; g_ovf = ovf_b; g_unf = unf_b;
    end
    sz = mq.size();
    check("rd_dv", int'(g_dv), exp_dv);
    check("rd_data", int'(g_data), exp_data);
    check("count", int'(g_cnt), sz);
    check("full", int'(g_full), (sz == depth) ? 1 : 0);
    check("empty", int'(g_empty), (sz == 0) ? 1 : 0);
    check("af", int'(g_af), (sz >= af_lvl) ? 1 : 0);
    check("ae", int'(g_ae), (sz <= ae_lvl) ? 1 : 0);
    check("overflow", int'(g_ovf), exp_ovf);
    check("underflow", int'(g_unf), exp_unf);
  endtask

  initial begin
    int   sent;
    logic w, r;
    logic [7:0] d;

    // Fill, overflow, drain on DEPTH=4.
    sel(0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b1, 8'h44, 1'b0, 1'b0);
    check("full_after_fill", int'(full_a), 1);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("empty_after_drain", int'(empty_a), 1);

    // Underflow and write+read on empty without fall-through.
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("a5_readback", int'(data_a), 32'hA5);

    // Simultaneous read+write while full.
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h61 + i), 1'b0, 1'b0);
    step(1'b1, 8'h66, 1'b1, 1'b0);
    check("rw_full_count", int'(cnt_a), 3);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Reset mid-read discards contents.
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b1, 8'h7E, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("7e_readback", int'(data_a), 32'h7E);

    // Random mix with occasional reset on DEPTH=4.
    for (int c = 0; c < 300; c++) begin
      w = ($urandom_range(0, 9) < 6);
      r = ($urandom_range(0, 9) < 5);
      d = 8'($urandom);
      step(w, d, r, ($urandom_range(0, 63) == 0));
    end

    // DEPTH=5: stream 20 words with 50% read duty across pointer wraps.
    sel(1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    sent = 0;
    for (int c = 0; c < 400 && (sent < 20 || mq.size() > 0); c++) begin
      w = (sent < 20) && ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 1) == 1);
      d = 8'(8'hA0 + sent);
      if (w && mq.size() < depth) sent++;
      step(w, d, r, 1'b0);
    end
    check("b_stream_empty", int'(empty_b), 1);
    check("b_stream_last", int'(data_b), 32'hA0 + 19);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
